// File: rtl/bitcoin_share_reporter.sv
// Miner result back end: expands nBits, compares block hashes,
// queues winning nonces and streams them to the host as framed bytes.
module bitcoin_share_reporter #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      target_bits,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0][31:0] in_digest,
  input  logic [31:0]      in_nonce,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [7:0]       tx_data,
  output logic [31:0]      found_count,
  output logic [15:0]      drop_count,
  output logic             busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_B0, S_B1, S_B2, S_B3, S_CHK
  } state_t;

  logic [255:0] hash_d, hash_q;
  logic [255:0] tgt_d, tgt_q;
  logic [31:0]  nonce_q;
  logic         cv_q;

  logic [7:0]   exp_w;
  logic [4:0]   up_w;
  logic [1:0]   dn_w;
  logic [287:0] mant_w;
  logic [255:0] shl_w, shr_w;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      hash_d[32*i +: 32] = {in_digest[i][7:0], in_digest[i][15:8],
                            in_digest[i][23:16], in_digest[i][31:24]};
    end
  end

  // Shift amounts only need to cover the legal exponent ranges.
  always_comb begin
    exp_w  = target_bits[31:24];
    up_w   = 5'(exp_w - 8'd3);
    dn_w   = 2'(8'd3 - exp_w);
    mant_w = {265'd0, target_bits[22:0]};
    shl_w  = 256'(mant_w << {up_w, 3'b000});
    shr_w  = 256'(mant_w >> {dn_w, 3'b000});
    if (target_bits[23])
      tgt_d = '0;
    else if (exp_w > 8'd32)
      tgt_d = '1;
    else if (exp_w >= 8'd3)
      tgt_d = shl_w;
    else
      tgt_d = shr_w;
  end

  assign in_ready = ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      cv_q    <= 1'b0;
      hash_q  <= '0;
      tgt_q   <= '0;
      nonce_q <= '0;
    end else begin
      cv_q <= in_valid & in_ready;
      if (in_valid & in_ready) begin
        hash_q  <= hash_d;
        tgt_q   <= tgt_d;
        nonce_q <= in_nonce;
      end
    end
  end

  logic            share_w, full_w, empty_w;
  logic            push_w, drop_w, pop_w;
  logic [31:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [AW:0]     cnt_q;
  logic [31:0]     found_q;
  logic [15:0]     drop_q;

  assign share_w = cv_q && (hash_q <= tgt_q);
  assign full_w  = (cnt_q == FULL_CNT);
  assign empty_w = (cnt_q == '0);
  // Fullness is judged before any same-cycle pop.
  assign push_w  = share_w && !full_w;
  assign drop_w  = share_w && full_w;

  always_ff @(posedge clk) begin
    if (push_w) mem_q[wptr_q] <= nonce_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      found_q <= '0;
      drop_q  <= '0;
    end else begin
      if (push_w) wptr_q <= wptr_q + 1'b1;
      if (pop_w) rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(push_w) - (AW+1)'(pop_w);
      if (share_w) found_q <= found_q + 32'd1;
      if (drop_w && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
    end
  end

  assign found_count = found_q;
  assign drop_count  = drop_q;

  state_t      state_q, state_d;
  logic [31:0] frame_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      if (pop_w) frame_q <= mem_q[rptr_q];
    end
  end

  always_comb begin
    state_d = state_q;
    pop_w   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty_w) begin
          pop_w   = 1'b1;
          state_d = S_SYNC;
        end
      end
      S_SYNC: if (tx_ready) state_d = S_B0;
      S_B0:   if (tx_ready) state_d = S_B1;
      S_B1:   if (tx_ready) state_d = S_B2;
      S_B2:   if (tx_ready) state_d = S_B3;
      S_B3:   if (tx_ready) state_d = S_CHK;
      S_CHK: begin
        if (tx_ready) begin
          if (!empty_w) begin
            pop_w   = 1'b1;
            state_d = S_SYNC;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_valid = 1'b1;
    tx_data  = '0;
    unique case (state_q)
      S_IDLE: tx_valid = 1'b0;
      S_SYNC: tx_data = SYNC_BYTE;
      S_B0:   tx_data = frame_q[7:0];
      S_B1:   tx_data = frame_q[15:8];
      S_B2:   tx_data = frame_q[23:16];
      S_B3:   tx_data = frame_q[31:24];
      S_CHK:  tx_data = frame_q[7:0] ^ frame_q[15:8] ^
                        frame_q[23:16] ^ frame_q[31:24];
      default: tx_valid = 1'b0;
    endcase
  end

  assign busy = cv_q | ~empty_w | (state_q != S_IDLE);

endmodule
